exc_ctrl: RTL and testbench

Exception sequencer that drives the CP0 exception/ERET interface from the pipeline side. It detects trap, interrupt and ERET events in the issuing instruction and prioritizes them. It then stalls the pipeline, issues a single-cycle `exception` (with `cause`, or with `eret`) to CP0, redirects the PC to CP0's `exc_addr`, and flushes. It also tracks handler nesting depth and the interrupt-enable state snooped from `mtc0` writes.

---
 rtl/exc_pkg.sv | 36 +++
 rtl/exc_ctrl_if.sv | 37 +++
 rtl/exc_timer.sv | 56 +++++
 rtl/exc_ctrl.sv | 158 +++++++++++++++
 tb/tb_exc_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: definitions shared by the exception sequencer files.
//   - ExcCode values that are driven onto the CP0 cause bus
//   - CP0 register indices that are snooped from mtc0 writes
//   - FSM state encoding
//   - depth_step(): nesting-depth update applied when the ENTER state exits
package exc_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENTER = 2'b01,
    ST_FLUSH = 2'b10
  } exc_state_e;

  // An ERET pops one level and saturates at zero. Every other event pushes
  // one level. Overflow is filtered out before ENTER, so the push cannot wrap.
  function automatic logic [2:0] depth_step(input logic [2:0] d, input logic is_eret);
    logic [2:0] r;
    if (is_eret) begin
      if (d == 3'd0) r = 3'd0;
      else           r = d - 3'd1;
    end else begin
      r = d + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline <-> exception sequencer signal bundle.
//   Pipeline to sequencer: instr_valid, syscall, brk, teq, teq_eq, eret_in,
//                          irq, mtc0, rd[4:0], wdata[31:0]
//   Sequencer to pipeline/CP0: stall, exception, eret, cause[4:0], pc_exc,
//                              flush, depth[2:0], ovf
//   Modports: master = pipeline side, slave = exc_ctrl.
interface exc_ctrl_if;
  logic        instr_valid;
  logic        syscall;
  logic        brk;
  logic        teq;
  logic        teq_eq;
  logic        eret_in;
  logic        irq;
  logic        mtc0;
  logic [4:0]  rd;
  logic [31:0] wdata;

  logic        stall;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic        pc_exc;
  logic        flush;
  logic [2:0]  depth;
  logic        ovf;

  modport master (
    output instr_valid, syscall, brk, teq, teq_eq, eret_in, irq, mtc0, rd, wdata,
    input  stall, exception, eret, cause, pc_exc, flush, depth, ovf
  );

  modport slave (
    input  instr_valid, syscall, brk, teq, teq_eq, eret_in, irq, mtc0, rd, wdata,
    output stall, exception, eret, cause, pc_exc, flush, depth, ovf
  );
endinterface

// File: rtl/exc_timer.sv
// exc_timer: CP0 Count/Compare timer that produces a pending timer interrupt.
// The module exists only when EXC_TIMER_IRQ_EN is defined.
//   clk, rst         : clock, asynchronous active-high reset
//   mtc0, rd, wdata  : snooped CP0 write (rd 9 loads count, rd 11 writes compare)
//   timer_pend       : set on count==compare (compare!=0), cleared by a compare write
`ifdef EXC_TIMER_IRQ_EN
module exc_timer
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic        timer_pend
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  // Next-state logic for count, compare and pending flag
  always_comb begin
    if (mtc0 && (rd == CP0_COUNT)) count_d = wdata;
    else                           count_d = count_q + 32'd1;

    // A compare write acknowledges the interrupt, so it takes precedence over a match
    if (mtc0 && (rd == CP0_COMPARE)) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      compare_d = compare_q;
      pend_d    = 1'b1;
    end else begin
      compare_d = compare_q;
      pend_d    = pend_q;
    end
  end

  // Timer register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign timer_pend = pend_q;

endmodule
`endif

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer on the pipeline side of the CP0 exception/ERET path.
// When an instruction is valid it detects ERET, TEQ traps, SYSCALL, BREAK and
// interrupts, and applies that priority order. It then stalls the pipeline, strobes
// CP0 for one cycle while the PC takes exc_addr, and flushes on the next cycle.
// Ports: clk, rst (async active-high); bus = exc_ctrl_if.slave.
// Optional feature: define EXC_TIMER_IRQ_EN to add the Count/Compare timer
// interrupt source (exc_timer), which is ORed into irq.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  localparam logic [2:0] MAX_D = 3'(MAX_DEPTH);

  exc_state_e  state_q, state_d;
  logic        enter_q, enter_d;
  logic        flush_q, flush_d;
  logic        eret_q, eret_d;
  logic [4:0]  cause_q, cause_d;
  logic [2:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        ie_q, ie_d;

  logic        irq_eff;
  logic        ev_eret, ev_tr, ev_sys, ev_bp, ev_int, ev_any;
  logic        at_max, accept, overflow;
  logic [4:0]  sel_cause;

`ifdef EXC_TIMER_IRQ_EN
  logic timer_pend;

  exc_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .mtc0       (bus.mtc0),
    .rd         (bus.rd),
    .wdata      (bus.wdata),
    .timer_pend (timer_pend)
  );

  assign irq_eff = bus.irq | timer_pend;
`else
  // Only bit 0 of wdata (Status.IE) matters without the timer
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^bus.wdata[31:1];
  assign irq_eff = bus.irq;
`endif

  // Event detection and prioritisation for the issuing instruction
  always_comb begin
    ev_eret = bus.instr_valid & bus.eret_in;
    ev_tr   = bus.instr_valid & bus.teq & bus.teq_eq;
    ev_sys  = bus.instr_valid & bus.syscall;
    ev_bp   = bus.instr_valid & bus.brk;
    // Interrupts are only taken at the outermost level
    ev_int  = bus.instr_valid & irq_eff & ie_q & (depth_q == 3'd0);
    ev_any  = ev_eret | ev_tr | ev_sys | ev_bp | ev_int;

    if (ev_eret)     sel_cause = EXC_INT;
    else if (ev_tr)  sel_cause = EXC_TR;
    else if (ev_sys) sel_cause = EXC_SYS;
    else if (ev_bp)  sel_cause = EXC_BP;
    else             sel_cause = EXC_INT;

    at_max   = (depth_q == MAX_D);
    // A push at full depth has no room left in Status, so it is dropped and flagged
    accept   = ev_any & (ev_eret | ~at_max);
    overflow = ev_any & ~ev_eret & at_max;
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    enter_d = enter_q;
    flush_d = 1'b0;
    eret_d  = eret_q;
    cause_d = cause_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;

    if (bus.mtc0 && (bus.rd == CP0_STATUS)) ie_d = bus.wdata[0];
    else                                    ie_d = ie_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ENTER;
          enter_d = 1'b1;
          eret_d  = ev_eret;
          cause_d = sel_cause;
        end else if (overflow) begin
          ovf_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENTER: begin
        // CP0 services mtc0 ahead of the strobe, so the FSM holds until the write is done
        if (bus.mtc0) begin
          state_d = ST_ENTER;
        end else begin
          state_d = ST_FLUSH;
          enter_d = 1'b0;
          eret_d  = 1'b0;
          flush_d = 1'b1;
          depth_d = depth_step(depth_q, eret_q);
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        enter_d = 1'b0;
        eret_d  = 1'b0;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      enter_q <= 1'b0;
      flush_q <= 1'b0;
      eret_q  <= 1'b0;
      cause_q <= 5'd0;
      depth_q <= 3'd0;
      ovf_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      flush_q <= flush_d;
      eret_q  <= eret_d;
      cause_q <= cause_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      ie_q    <= ie_d;
    end
  end

  // stall has to take effect in the same cycle that the event is detected
  assign bus.stall     = enter_q | ((state_q == ST_IDLE) & accept);
  assign bus.exception = enter_q & ~bus.mtc0;
  assign bus.eret      = eret_q;
  assign bus.cause     = cause_q;
  assign bus.pc_exc    = enter_q;
  assign bus.flush     = flush_q;
  assign bus.depth     = depth_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed test of exc_ctrl. A behavioural model is evaluated on every
// falling edge and compared with all outputs. Literal checks pin the key points.
module tb_exc_ctrl;

  logic clk = 1'b0;
  logic rst;
  exc_ctrl_if bus();

  exc_ctrl #(.MAX_DEPTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;   // 0 free, 1 waiting for CP0 strobe, 2 flushing
  logic        m_ie;
  int          m_depth;
  logic        m_ovf;
  logic [4:0]  m_cause;
  logic        m_eret;
  logic [31:0] m_count, m_cmp;
  logic        m_pend;
  logic        e_stall, e_exc, e_eret, e_pc, e_flush;
  logic        ev, is_eret, irq_e;
  logic [4:0]  ev_cause;

  function automatic logic [31:0] act_vec();
    return {23'd0, bus.stall, bus.exception, bus.eret, bus.pc_exc, bus.flush, bus.ovf, bus.depth};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_ie = 1'b0; m_depth = 0; m_ovf = 1'b0; m_cause = 5'd0; m_eret = 1'b0;
      m_count = 32'd0; m_cmp = 32'd0; m_pend = 1'b0;
      check("reset_outputs", act_vec(), 32'd0);
      check("reset_cause", {27'd0, bus.cause}, 32'd0);
    end else begin
`ifdef EXC_TIMER_IRQ_EN
      irq_e = bus.irq | m_pend;
`else
      irq_e = bus.irq;
`endif
      e_stall = 1'b0; e_exc = 1'b0; e_eret = 1'b0; e_pc = 1'b0; e_flush = 1'b0;
      ev = 1'b0; is_eret = 1'b0; ev_cause = 5'd0;
      if (m_phase == 0) begin
        is_eret = bus.instr_valid & bus.eret_in;
        ev = bus.instr_valid & (bus.eret_in | (bus.teq & bus.teq_eq) | bus.syscall | bus.brk
                                | (irq_e & m_ie & (m_depth == 0)));
        if (is_eret)                   ev_cause = 5'd0;
        else if (bus.teq & bus.teq_eq) ev_cause = 5'd13;
        else if (bus.syscall)          ev_cause = 5'd8;
        else if (bus.brk)              ev_cause = 5'd9;
        else                           ev_cause = 5'd0;
        e_stall = ev & (is_eret | (m_depth < 6));
      end else if (m_phase == 1) begin
        e_stall = 1'b1; e_pc = 1'b1; e_exc = ~bus.mtc0; e_eret = m_eret;
      end else begin
        e_flush = 1'b1;
      end

      check("outputs", act_vec(),
            {23'd0, e_stall, e_exc, e_eret, e_pc, e_flush, m_ovf, 3'(m_depth)});
      if (e_exc) check("cause", {27'd0, bus.cause}, {27'd0, m_cause});

      // advance the model by one clock
      if (m_phase == 0) begin
        if (e_stall) begin m_phase = 1; m_cause = ev_cause; m_eret = is_eret; end
        else if (ev) m_ovf = 1'b1;
      end else if (m_phase == 1) begin
        if (!bus.mtc0) begin
          m_phase = 2;
          if (m_eret) m_depth = (m_depth > 0) ? m_depth - 1 : 0;
          else        m_depth = m_depth + 1;
        end
      end else begin
        m_phase = 0;
      end
      if (bus.mtc0 && bus.rd == 5'd12) m_ie = bus.wdata[0];
      if (bus.mtc0 && bus.rd == 5'd11) begin m_cmp = bus.wdata; m_pend = 1'b0; end
      else if (m_count == m_cmp && m_cmp != 32'd0) m_pend = 1'b1;
      if (bus.mtc0 && bus.rd == 5'd9) m_count = bus.wdata;
      else                            m_count = m_count + 32'd1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    bus.instr_valid = 1'b0; bus.syscall = 1'b0; bus.brk = 1'b0; bus.teq = 1'b0;
    bus.teq_eq = 1'b0; bus.eret_in = 1'b0; bus.irq = 1'b0; bus.mtc0 = 1'b0;
    bus.rd = 5'd0; bus.wdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // ERET from IDLE through to the next IDLE, with the depth afterwards pinned
  task automatic do_eret(input logic [2:0] exp_depth);
    clr(); bus.instr_valid = 1'b1; bus.eret_in = 1'b1;
    step(); clr();
    mid(); check("eret_strobe", {30'd0, bus.exception, bus.eret}, 32'd3);
    step();
    mid(); check("eret_depth", {29'd0, bus.depth}, {29'd0, exp_depth});
    step();
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) step();
    check("rst_depth", {29'd0, bus.depth}, 32'd0);
    rst = 1'b0;
    step();

    // SYSCALL: stall same cycle, strobe next, flush after
    bus.instr_valid = 1'b1; bus.syscall = 1'b1;
    mid(); check("sys_stall", {31'd0, bus.stall}, 32'd1);
    step(); clr();
    mid(); check("sys_exc", {25'd0, bus.exception, bus.pc_exc, bus.cause}, {25'd0, 2'b11, 5'd8});
    step();
    mid(); check("sys_flush", {28'd0, bus.flush, bus.depth}, {28'd0, 1'b1, 3'd1});
    step();
    do_eret(3'd0);

    // Interrupt gated by ie, then by depth
    bus.instr_valid = 1'b1; bus.irq = 1'b1;
    mid(); check("irq_ie0", {31'd0, bus.stall}, 32'd0);
    step(); clr();
    bus.mtc0 = 1'b1; bus.rd = 5'd12; bus.wdata = 32'd1;
    step(); clr();
    bus.instr_valid = 1'b1; bus.irq = 1'b1;
    mid(); check("irq_stall", {31'd0, bus.stall}, 32'd1);
    step(); bus.instr_valid = 1'b0;
    mid(); check("irq_exc", {26'd0, bus.exception, bus.cause}, {26'd0, 1'b1, 5'd0});
    step(); step();
    bus.instr_valid = 1'b1;
    mid(); check("irq_nested", {31'd0, bus.stall}, 32'd0);
    step();
    do_eret(3'd0);

    // mtc0 holds the FSM in ENTER for two cycles
    bus.instr_valid = 1'b1; bus.syscall = 1'b1;
    step(); clr();
    bus.mtc0 = 1'b1; bus.rd = 5'd5;
    mid(); check("mtc0_hold1", {30'd0, bus.exception, bus.pc_exc}, 32'd1);
    step();
    mid(); check("mtc0_hold2", {30'd0, bus.exception, bus.pc_exc}, 32'd1);
    step(); bus.mtc0 = 1'b0;
    mid(); check("mtc0_release", {26'd0, bus.exception, bus.cause}, {26'd0, 1'b1, 5'd8});
    step(); step();
    do_eret(3'd0);

    // Seven nested BREAKs: the seventh overflows
    for (int i = 0; i < 7; i++) begin
      bus.instr_valid = 1'b1; bus.brk = 1'b1;
      mid(); check("brk_stall", {31'd0, bus.stall}, (i < 6) ? 32'd1 : 32'd0);
      step(); clr();
      if (i == 6) begin
        mid(); check("ovf_depth", {28'd0, bus.ovf, bus.depth}, {28'd0, 1'b1, 3'd6});
      end
      step(); step();
    end
    bus.instr_valid = 1'b1; bus.teq = 1'b1;
    mid(); check("teq_ne", {31'd0, bus.stall}, 32'd0);
    step(); clr();
    // ERET wins over SYSCALL when both are present
    bus.instr_valid = 1'b1; bus.eret_in = 1'b1; bus.syscall = 1'b1;
    step(); clr();
    mid(); check("eret_prio", {30'd0, bus.exception, bus.eret}, 32'd3);
    step(); step();
    for (int d = 4; d >= 0; d--) do_eret(3'(d));
    do_eret(3'd0);   // ERET at depth 0 is still issued to CP0
    // TEQ wins over SYSCALL
    bus.instr_valid = 1'b1; bus.teq = 1'b1; bus.teq_eq = 1'b1; bus.syscall = 1'b1;
    step(); clr();
    mid(); check("teq_cause", {27'd0, bus.cause}, 32'd13);
    step(); step();
    do_eret(3'd0);
    // SYSCALL wins over BREAK
    bus.instr_valid = 1'b1; bus.syscall = 1'b1; bus.brk = 1'b1;
    step(); clr();
    mid(); check("sys_brk_cause", {27'd0, bus.cause}, 32'd8);
    step(); step();
    do_eret(3'd0);

    // Asynchronous reset in the middle of ENTER
    bus.instr_valid = 1'b1; bus.syscall = 1'b1;
    step(); clr();
    #2 rst = 1'b1;
    #1 check("async_rst", act_vec(), 32'd0);
    step(); rst = 1'b0;
    step();

`ifdef EXC_TIMER_IRQ_EN
    begin
      logic hit;
      hit = 1'b0;
      bus.mtc0 = 1'b1; bus.rd = 5'd12; bus.wdata = 32'd1; step();
      bus.rd = 5'd9;  bus.wdata = 32'd0; step();
      bus.rd = 5'd11; bus.wdata = 32'd5; step();
      clr(); bus.instr_valid = 1'b1;
      for (int i = 0; i < 30 && !hit; i++) begin
        mid();
        if (bus.stall) hit = 1'b1;
        else step();
      end
      check("timer_hit", {31'd0, hit}, 32'd1);
      step(); clr();
      mid(); check("timer_exc", {26'd0, bus.exception, bus.cause}, {26'd0, 1'b1, 5'd0});
      step(); step();
      bus.mtc0 = 1'b1; bus.rd = 5'd11; bus.wdata = 32'd0;
      step(); clr();
      do_eret(3'd0);
      bus.instr_valid = 1'b1;
      mid(); check("timer_cleared", {31'd0, bus.stall}, 32'd0);
      step(); clr();
    end
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
